// File: rtl/ic_line_fill.sv
// I-cache line fill: issues one 4-beat read burst per miss, assembles the
// 128-bit line and hands it to the tag/RAM write stage for one cycle.
module ic_line_fill #(
    parameter int IWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_pipe,
    input  logic              icr_start_rq,
    input  logic [31:0]       ic_rin_addr,
    output logic              arvalid,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    input  logic              arready,
    input  logic              rvalid,
    input  logic [31:0]       rdata,
    input  logic              rlast,
    output logic              rready,
    output logic              ic_rdat_m_valid,
    output logic [127:0]      ic_ram_wdata_all,
    output logic [IWIDTH-3:0] ic_ram_wadr_all,
    output logic              ic_finish_mrd,
    output logic              ic_fill_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AREQ  = 3'd1,
        S_RDAT  = 3'd2,
        S_WRT   = 3'd3,
        S_FIN   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [31:4]      addr_q;
    logic [1:0]       beat_cnt_q;
    logic [3:0][31:0] line_q;
    logic             arvalid_q;
    logic             rready_q;
    logic             m_valid_q;
    logic             finish_q;
    logic             beat_last;
    logic             unused_addr_bits;

    assign beat_last        = rvalid && (beat_cnt_q == 2'd3);
    assign unused_addr_bits = ^ic_rin_addr[3:0];

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (icr_start_rq && !rst_pipe) state_d = S_AREQ;
            S_AREQ: begin
                if (rst_pipe)     state_d = arready ? S_DRAIN : S_IDLE;
                else if (arready) state_d = S_RDAT;
            end
            S_RDAT: begin
                if (beat_last)     state_d = rst_pipe ? S_FIN : S_WRT;
                else if (rst_pipe) state_d = S_DRAIN;
            end
            S_WRT:   state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            S_DRAIN: if (beat_last) state_d = S_FIN;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            beat_cnt_q <= 2'd0;
            line_q     <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            // Handshake outputs are registered from the next state, so they track state_q exactly.
            arvalid_q <= (state_d == S_AREQ);
            rready_q  <= (state_d == S_RDAT) || (state_d == S_DRAIN);
            m_valid_q <= (state_d == S_WRT);
            finish_q  <= (state_d == S_FIN);

            case (state_q)
                S_IDLE: begin
                    if (state_d == S_AREQ) begin
                        addr_q     <= ic_rin_addr[31:4];
                        beat_cnt_q <= 2'd0;
                        line_q     <= '0;
                    end
                end
                S_RDAT: begin
                    if (rvalid) begin
                        line_q[beat_cnt_q] <= rdata;
                        beat_cnt_q         <= beat_cnt_q + 2'd1;
                    end
                end
                S_DRAIN: begin
                    if (rvalid) beat_cnt_q <= beat_cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign arvalid          = arvalid_q;
    assign araddr           = {addr_q, 4'b0000};
    assign arlen            = 8'd3;
    assign rready           = rready_q;
    assign ic_rdat_m_valid  = m_valid_q;
    assign ic_finish_mrd    = finish_q;
    assign ic_ram_wdata_all = line_q;
    assign ic_ram_wadr_all  = addr_q[IWIDTH+1:4];

    // rlast must mark beat 3 and only beat 3; flagged in the cycle the beat is accepted.
    assign ic_fill_err = rready_q && rvalid && (rlast != (beat_cnt_q == 2'd3));

endmodule

// File: tb/tb_ic_line_fill.sv
// Directed bench for ic_line_fill; a negedge monitor checks every written line
// against a scoreboard queue filled when each fill is issued.
module tb_ic_line_fill;

    localparam int IWIDTH = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rst_pipe = 1'b0;
    logic              icr_start_rq = 1'b0;
    logic [31:0]       ic_rin_addr = '0;
    logic              arvalid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic              arready = 1'b0;
    logic              rvalid = 1'b0;
    logic [31:0]       rdata = '0;
    logic              rlast = 1'b0;
    logic              rready;
    logic              ic_rdat_m_valid;
    logic [127:0]      ic_ram_wdata_all;
    logic [IWIDTH-3:0] ic_ram_wadr_all;
    logic              ic_finish_mrd;
    logic              ic_fill_err;

    ic_line_fill #(.IWIDTH(IWIDTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .rst_pipe         (rst_pipe),
        .icr_start_rq     (icr_start_rq),
        .ic_rin_addr      (ic_rin_addr),
        .arvalid          (arvalid),
        .araddr           (araddr),
        .arlen            (arlen),
        .arready          (arready),
        .rvalid           (rvalid),
        .rdata            (rdata),
        .rlast            (rlast),
        .rready           (rready),
        .ic_rdat_m_valid  (ic_rdat_m_valid),
        .ic_ram_wdata_all (ic_ram_wdata_all),
        .ic_ram_wadr_all  (ic_ram_wadr_all),
        .ic_finish_mrd    (ic_finish_mrd),
        .ic_fill_err      (ic_fill_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IWIDTH-3:0] wadr;
        logic [127:0]      wdata;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    int n_ar = 0, n_valid = 0, n_fin = 0, n_err = 0;

    logic        prev_valid = 1'b0;
    logic        prev_arwait = 1'b0;
    logic        prev_abort = 1'b0;
    logic [31:0] prev_araddr = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (arvalid && arready) n_ar++;
        if (ic_finish_mrd) n_fin++;
        if (ic_fill_err) n_err++;
        if (prev_valid) check("finish_after_valid", 128'(ic_finish_mrd), 128'(1));
        if (prev_arwait && !prev_abort) begin
            check("arvalid_held", 128'(arvalid), 128'(1));
            check("araddr_held", 128'(araddr), 128'(prev_araddr));
        end
        if (ic_rdat_m_valid) begin
            n_valid++;
            valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_fill", 128'(ic_rdat_m_valid), 128'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("line_wadr", 128'(ic_ram_wadr_all), 128'(e.wadr));
                check("line_wdata", ic_ram_wdata_all, e.wdata);
            end
        end
        prev_valid  = ic_rdat_m_valid;
        prev_arwait = arvalid && !arready;
        prev_abort  = rst_pipe || rst;
        prev_araddr = araddr;
    end

    // One complete request: AR handshake after ar_delay cycles, beats gated by rv_pat.
    task automatic run_fill(input logic [31:0] addr, input logic [31:0] exp_araddr,
                            input int ar_delay, input logic [7:0] rv_pat,
                            input logic [3:0] rlast_mask, input int pipe_beat,
                            input int dup_beat, input logic [127:0] data,
                            output logic [3:0] err_seen);
        int b;
        int i;
        err_seen = 4'b0000;
        @(posedge clk); #1;
        icr_start_rq = 1'b1;
        ic_rin_addr  = addr;
        start_cyc    = cyc;
        @(posedge clk); #1;
        icr_start_rq = 1'b0;
        ic_rin_addr  = 32'hA5A5_A5A5;
        check("areq_arvalid", 128'(arvalid), 128'(1));
        check("areq_araddr", 128'(araddr), 128'(exp_araddr));
        check("areq_arlen", 128'(arlen), 128'(8'd3));
        for (int k = 0; k < ar_delay; k++) begin
            @(posedge clk); #1;
        end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        b = 0;
        i = 0;
        while (b < 4 && i < 64) begin
            rvalid = rv_pat[i % 8];
            if (rvalid) begin
                rdata    = data[32*b +: 32];
                rlast    = rlast_mask[b];
                rst_pipe = (b == pipe_beat);
            end
            if (b == dup_beat) begin
                icr_start_rq = 1'b1;
                ic_rin_addr  = 32'hFFFF_FFF0;
            end
            @(negedge clk);
            if (rvalid) err_seen[b] = ic_fill_err;
            @(posedge clk); #1;
            if (rvalid) b++;
            rvalid = 1'b0; rlast = 1'b0; rst_pipe = 1'b0; icr_start_rq = 1'b0;
            i++;
        end
        if (b < 4) check("beats_accepted", 128'(b), 128'(4));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [3:0] err_seen;
        int ar0, fin0, val0, err0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_arvalid", 128'(arvalid), 128'(0));
        check("rst_rready", 128'(rready), 128'(0));
        check("rst_araddr", 128'(araddr), 128'(0));
        check("rst_arlen", 128'(arlen), 128'(8'd3));
        check("rst_valid", 128'(ic_rdat_m_valid), 128'(0));
        check("rst_finish", 128'(ic_finish_mrd), 128'(0));
        rst = 1'b0;

        // Back-to-back fill with minimum latency.
        val0 = n_valid; ar0 = n_ar;
        exp_q.push_back('{12'h123, 128'h00000044_00000033_00000022_00000011});
        run_fill(32'h0000_1234, 32'h0000_1230, 0, 8'hFF, 4'b1000, -1, -1,
                 128'h00000044_00000033_00000022_00000011, err_seen);
        repeat (3) @(posedge clk);
        #1;
        check("t1_latency", 128'(valid_cyc - start_cyc), 128'(6));
        check("t1_err", 128'(err_seen), 128'(4'b0000));
        check("t1_ar_count", 128'(n_ar - ar0), 128'(1));
        check("t1_valid_count", 128'(n_valid - val0), 128'(1));

        // Delayed arready, gapped rvalid (1-0-1-0-1-1-0-1).
        val0 = n_valid;
        exp_q.push_back('{12'hABC, 128'hCAFEF00D_12345678_A5A5A5A5_DEADBEEF});
        run_fill(32'h0000_ABCC, 32'h0000_ABC0, 3, 8'hB5, 4'b1000, -1, -1,
                 128'hCAFEF00D_12345678_A5A5A5A5_DEADBEEF, err_seen);
        repeat (3) @(posedge clk);
        #1;
        check("t2_valid_count", 128'(n_valid - val0), 128'(1));

        // rst_pipe on beat 1: drain the rest, no line write, one finish.
        val0 = n_valid; fin0 = n_fin;
        run_fill(32'h0000_4440, 32'h0000_4440, 0, 8'hFF, 4'b1000, 1, -1,
                 128'h99999999_88888888_77777777_66666666, err_seen);
        repeat (3) @(posedge clk);
        #1;
        check("t3_no_valid", 128'(n_valid - val0), 128'(0));
        check("t3_finish_count", 128'(n_fin - fin0), 128'(1));

        // rlast early on beat 2 (and on beat 3): one error pulse, fill completes.
        val0 = n_valid; err0 = n_err;
        exp_q.push_back('{12'h004, 128'h44444444_33333333_22222222_11111111});
        run_fill(32'h8000_0040, 32'h8000_0040, 0, 8'hFF, 4'b1100, -1, -1,
                 128'h44444444_33333333_22222222_11111111, err_seen);
        repeat (3) @(posedge clk);
        #1;
        check("t4_err_beat", 128'(err_seen), 128'(4'b0100));
        check("t4_err_count", 128'(n_err - err0), 128'(1));
        check("t4_valid_count", 128'(n_valid - val0), 128'(1));

        // Second start during RDAT is dropped.
        ar0 = n_ar;
        exp_q.push_back('{12'h567, 128'h0000000D_0000000C_0000000B_0000000A});
        run_fill(32'h0000_5670, 32'h0000_5670, 0, 8'hFF, 4'b1000, -1, 1,
                 128'h0000000D_0000000C_0000000B_0000000A, err_seen);
        repeat (5) @(posedge clk);
        #1;
        check("t5_ar_count", 128'(n_ar - ar0), 128'(1));
        check("t5_idle_arvalid", 128'(arvalid), 128'(0));

        // rst_pipe in AREQ before acceptance: no bus transaction.
        ar0 = n_ar; fin0 = n_fin;
        @(posedge clk); #1;
        icr_start_rq = 1'b1; ic_rin_addr = 32'h0000_2000;
        @(posedge clk); #1;
        icr_start_rq = 1'b0; rst_pipe = 1'b1;
        @(posedge clk); #1;
        rst_pipe = 1'b0;
        check("t6_arvalid_dropped", 128'(arvalid), 128'(0));
        arready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        arready = 1'b0;
        check("t6_ar_count", 128'(n_ar - ar0), 128'(0));
        check("t6_finish_count", 128'(n_fin - fin0), 128'(0));

        // rst mid-RDAT: abandon burst, outputs back to reset values.
        val0 = n_valid;
        @(posedge clk); #1;
        icr_start_rq = 1'b1; ic_rin_addr = 32'h0000_3450;
        @(posedge clk); #1;
        icr_start_rq = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_2222;
        @(posedge clk); #1;
        rdata = 32'h3333_4444;
        @(posedge clk); #1;
        rvalid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t7_arvalid", 128'(arvalid), 128'(0));
        check("t7_rready", 128'(rready), 128'(0));
        check("t7_araddr", 128'(araddr), 128'(0));
        check("t7_arlen", 128'(arlen), 128'(8'd3));
        check("t7_wdata", ic_ram_wdata_all, 128'(0));
        check("t7_wadr", 128'(ic_ram_wadr_all), 128'(0));
        check("t7_finish", 128'(ic_finish_mrd), 128'(0));
        check("t7_err", 128'(ic_fill_err), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        check("t7_no_valid", 128'(n_valid - val0), 128'(0));

        // Recovery fill at the top of the index range.
        exp_q.push_back('{12'hFFF, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000});
        run_fill(32'h1234_FFF8, 32'h1234_FFF0, 1, 8'hFF, 4'b1000, -1, -1,
                 128'hFFFFFFFF_00000000_FFFFFFFF_00000000, err_seen);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        check("total_valid", 128'(n_valid), 128'(5));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ic_line_fill.md
IC_LINE_FILL -- requirements
Module: ic_line_fill

Interface
REQ-001 Parameter IWIDTH, default 14, I-cache RAM index width; line index = ic_rin_addr[IWIDTH+1:4].
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rst_pipe  in  1  pipeline reset; aborts the fill in progress (see REQ-020).
REQ-005 icr_start_rq  in  1  one-cycle line-fill request from the I-cache miss stage.
REQ-006 ic_rin_addr  in  32  miss address; sampled only in the cycle icr_start_rq is high.
REQ-007 arvalid  out  1  read-address valid.
REQ-008 araddr  out  32  line-aligned read address.
REQ-009 arlen  out  8  burst length minus one; constant 8'd3.
REQ-010 arready  in  1  read-address accepted.
REQ-011 rvalid  in  1  read-data beat valid.
REQ-012 rdata  in  32  read-data beat.
REQ-013 rlast  in  1  final beat marker.
REQ-014 rready  out  1  read-data ready.
REQ-015 ic_rdat_m_valid  out  1  one-cycle pulse: line assembled, tag/RAM write this cycle.
REQ-016 ic_ram_wdata_all  out  128  assembled line; beat n in bits [32n+31:32n].
REQ-017 ic_ram_wadr_all  out  IWIDTH-2  line index for the RAM write.
REQ-018 ic_finish_mrd  out  1  one-cycle pulse one cycle after ic_rdat_m_valid; also pulses on a completed drain.
REQ-019 ic_fill_err  out  1  one-cycle pulse when rlast does not match beat 3.

Function
REQ-020 States: IDLE, AREQ, RDAT, WRT, FIN, DRAIN; encoding 3 bits; unused codes go to IDLE.
REQ-021 IDLE: icr_start_rq=1 -> latch {ic_rin_addr[31:4],4'b0} into addr register, clear beat counter and line buffer, go AREQ; rst_pipe=1 in the same cycle has priority and drops the request.
REQ-022 AREQ: arvalid=1, araddr=addr register; arready=1 -> RDAT next cycle; araddr and arvalid stable until accepted.
REQ-023 RDAT: rready=1; each rvalid beat writes rdata into slot beat_cnt and increments the 2-bit counter; beat 3 (counter 2'd3 with rvalid) -> WRT.
REQ-024 WRT: ic_rdat_m_valid=1 for exactly one cycle; ic_ram_wdata_all and ic_ram_wadr_all valid and held through FIN -> FIN.
REQ-025 FIN: ic_finish_mrd=1 for one cycle -> IDLE.
REQ-026 Minimum latency icr_start_rq -> ic_rdat_m_valid, with arready high and rvalid high every cycle: 6 cycles (1 AREQ + 4 RDAT + WRT entry).
REQ-027 icr_start_rq outside IDLE is ignored; no queuing.
REQ-028 rlast high on beats 0-2, or low on beat 3 -> ic_fill_err pulse on that beat; the fill still completes on counter alone.
REQ-029 rst_pipe in AREQ before acceptance -> IDLE, no bus transaction issued; rst_pipe in AREQ coincident with arready, or in RDAT -> DRAIN.
REQ-030 DRAIN: rready=1, remaining beats counted and discarded; after beat 3 -> FIN (ic_finish_mrd pulse), ic_rdat_m_valid never asserted for an aborted fill.
REQ-031 rst_pipe in WRT or FIN has no effect; the line completes.
REQ-032 rready=0 and arvalid=0 in every state not listed above.

Reset
REQ-033 rst=1 -> state IDLE, beat counter 0, addr register 0, line buffer 0; all outputs 0 except arlen=8'd3; takes effect next edge and overrides rst_pipe and all inputs.
REQ-034 rst asserted mid-burst abandons the burst without drain; the bus slave is reset by the same rst.

Verification
REQ-035 Start addr 32'h0000_1234, arready same cycle, beats 11,22,33,44 back-to-back with rlast on 4th -> araddr 32'h0000_1230, ic_ram_wadr_all 12'h123, ic_ram_wdata_all 128'h44_0000_0033_0000_0022_0000_0011 (32-bit slots), ic_rdat_m_valid 6 cycles after start, ic_finish_mrd next cycle.
REQ-036 arready delayed 3 cycles, rvalid gapped (1-0-1-0-1-1-0-1) -> araddr/arvalid stable while waiting, line correct, exactly one ic_rdat_m_valid.
REQ-037 rst_pipe during beat 1 -> DRAIN, beats 2-3 accepted, no ic_rdat_m_valid, one ic_finish_mrd after beat 3, next start serviced normally.
REQ-038 rlast asserted on beat 2 -> ic_fill_err pulse on beat 2, fill completes after beat 3.
REQ-039 Second icr_start_rq during RDAT -> ignored, single AR transaction observed; rst mid-RDAT -> IDLE next cycle, all outputs at reset values.
